shift_add_mult_32: RTL and testbench

//  Sequential unsigned 32x32 -> 64-bit multiplier built around the team's 32-bit ripple-carry adder (RCA_32_bit).
//  One shift-and-add step per clock: drives the adder operands each cycle and consumes its 32-bit sum plus carry-out.

---
 rtl/mult_pkg.sv | 13 +
 rtl/RCA_32_bit.sv | 21 ++
 rtl/shift_add_mult_32.sv | 100 ++++++++++
 tb/tb_shift_add_mult_32.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding and operand sizing.
package mult_pkg;

   localparam int MULT_W     = 32;
   localparam int MULT_STEPS = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/RCA_32_bit.sv
// 32-bit ripple-carry adder; the carry propagates bit by bit from c_in to c_out.
module RCA_32_bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        c_in,
   output logic [31:0] s,
   output logic        c_out
);

   always_comb begin
      logic carry;
      carry = c_in;
      s     = '0;
      for (int i = 0; i < 32; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
   end

endmodule

// File: rtl/shift_add_mult_32.sv
// Sequential unsigned 32x32->64 multiplier: one shift-and-add step per clock through RCA_32_bit,
// with valid/ready handshakes on the operand and product sides.
module shift_add_mult_32
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_W,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   assign add_b = lo_q[0] ? mcand_q : '0;

   RCA_32_bit u_add (
      .a     (hi_q),
      .b     (add_b),
      .c_in  (1'b0),
      .s     (add_sum),
      .c_out (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // The adder carry lands in the top product bit as the 65-bit {c_out, sum, lo} value shifts right.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      p         = '0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mcand_d = a;
               lo_d    = b;
               hi_d    = '0;
               count_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy          = 1'b1;
            {hi_d, lo_d}  = {add_cout, add_sum, lo_q[WIDTH-1:1]};
            count_d       = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            p         = {hi_q, lo_q};
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_add_mult_32.sv
// Self-checking bench for shift_add_mult_32: directed vector table, back-pressure, reset abort,
// back-to-back and random operands checked against a plain a*b reference.
module tb_shift_add_mult_32;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] p;
   logic        busy;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_p;
      int          bp_cycles;
      bit          pulse_in_valid;
   } vec_t;

   vec_t vecs[4];

   shift_add_mult_32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      return 64'(x) * 64'(y);
   endfunction

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, presents one operand pair for a single accept edge, then scrambles a/b.
   task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y);
      int waited;
      waited = 0;
      while (!in_ready && waited < 100) begin
         tick();
         waited++;
      end
      check("in_ready_wait", 64'(waited < 100), 64'd1);
      in_valid = 1'b1;
      a_i      = x;
      b_i      = y;
      tick();
      in_valid = 1'b0;
      a_i      = $urandom;
      b_i      = $urandom;
      check("busy_after_accept", 64'(busy), 64'd1);
      check("in_ready_after_accept", 64'(in_ready), 64'd0);
   endtask

   task automatic check_output(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp_p,
                               input int bp_cycles, input bit pulse);
      int lat;
      logic [63:0] held;
      lat = 0;
      while (!out_valid && lat < 64) begin
         tick();
         lat++;
      end
      check("latency", 64'(lat), 64'd32);
      check("busy_in_done", 64'(busy), 64'd0);
      check("product_table", p, exp_p);
      check("product_model", p, ref_mul(x, y));
      held = p;
      for (int i = 0; i < bp_cycles; i++) begin
         in_valid = pulse & i[0];
         a_i      = $urandom;
         b_i      = $urandom;
         tick();
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_p_stable", p, held);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("handoff_out_valid", 64'(out_valid), 64'd0);
      check("handoff_p_zero", p, 64'd0);
      check("handoff_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] exp_q[$];
      logic [31:0] pa[4];
      logic [31:0] pb[4];
      int          idx;
      int          last_accept;
      int          got;
      logic [31:0] ra;
      logic [31:0] rb;

      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      a_i          = '0;
      b_i          = '0;

      vecs[0] = '{32'h0000_0007, 32'h0000_0000, 64'h0,                     0,  1'b0};
      vecs[1] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F,   1,  1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,   2,  1'b0};
      vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080,   10, 1'b1};

      #12;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_p", p, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("reset_in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].a, vecs[i].b);
         check_output(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].bp_cycles, vecs[i].pulse_in_valid);
      end

      // Abort part-way through the multiply and confirm nothing of it survives.
      apply_stimulus(32'hDEAD_BEEF, 32'hCAFE_F00D);
      repeat (15) tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_p", p, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      apply_stimulus(32'd2, 32'd9);
      check_output(32'd2, 32'd9, 64'd18, 0, 1'b0);

      // Back-to-back with in_valid held high; accepts must be spaced 34 edges apart.
      for (int i = 0; i < 4; i++) begin
         pa[i] = $urandom;
         pb[i] = $urandom;
      end
      idx         = 0;
      last_accept = -1;
      got         = 0;
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      a_i         = pa[0];
      b_i         = pb[0];
      for (int cyc = 0; cyc < 400 && got < 4; cyc++) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_mul(pa[idx], pb[idx]));
            if (last_accept >= 0) check("b2b_spacing", 64'(cyc - last_accept), 64'd34);
            last_accept = cyc;
            idx++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) check("b2b_product", p, exp_q.pop_front());
            else check("b2b_unexpected_output", 64'd1, 64'd0);
            got++;
         end
         tick();
         if (idx < 4) begin
            a_i = pa[idx];
            b_i = pb[idx];
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_count", 64'(got), 64'd4);
      tick();

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = (i == 0) ? 32'h8000_0000 : $urandom;
         apply_stimulus(ra, rb);
         check_output(ra, rb, ref_mul(ra, rb), int'($urandom_range(0, 3)), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
